// File: rtl/mux4_pkg.sv
// Shared definitions for the round-robin mux4 controller: state encoding,
// requester count and a one-hot helper.
package mux4_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/mux4.sv
// Existing 4:1 single-bit datapath mux; s selects which a[] bit reaches y.
module mux4 (
    input  logic [3:0] a,
    input  logic [1:0] s,
    output logic       y
);
    assign y = a[s];
endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: the first requester after `last` (mod 4)
// with req high wins; `last` itself has the lowest priority.
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] win
);
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    // rot[0] is the requester immediately after last, rot[3] is last itself
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        assign rot[gi] = req[SEL_W'(last + SEL_W'(gi + 1))];
    end

    always_comb begin
        off = '0;
        casez (rot)
            4'b???1: off = 2'd0;
            4'b??10: off = 2'd1;
            4'b?100: off = 2'd2;
            4'b1000: off = 2'd3;
            default: off = 2'd0;
        endcase
    end

    assign any = |req;
    assign win = SEL_W'(last + off + 2'd1);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the shared mux4: grants one requester for up to HOLD
// beats, drives the mux select and registers the selected bit with a valid flag.
module mux4_rr_arbiter
    import mux4_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] a,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             y,
    output logic             y_valid,
    output logic             busy
);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HOLD - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             y_valid_q, y_valid_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_win;
    logic             mux_y;
    logic             rearb;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .win  (pick_win)
    );

    mux4 u_mux (
        .a (a),
        .s (sel_q),
        .y (mux_y)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        rearb     = 1'b0;

        if (state_q == IDLE) begin
            rearb = 1'b1;
        end else if (req[sel_q]) begin
            y_d       = mux_y;
            y_valid_d = 1'b1;
            if (cnt_q == LAST_BEAT) begin
                rearb = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            rearb = 1'b1;
        end

        // While granted last_q equals sel_q, so the releasing requester ends up last in line
        if (rearb) begin
            if (pick_any) begin
                state_d = GRANT;
                gnt_d   = onehot(pick_win);
                sel_d   = pick_win;
                last_d  = pick_win;
                cnt_d   = '0;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q == GRANT);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one HOLD=4 instance and one HOLD=1 instance.
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n, rst_b_n;
    logic [3:0] req, a, req_b, a_b;
    logic [3:0] gnt, gnt_b;
    logic [1:0] sel, sel_b;
    logic       y, y_valid, busy, y_b, y_valid_b, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.HOLD(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a),
        .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .busy(busy)
    );

    mux4_rr_arbiter #(.HOLD(1), .CNT_W(4)) dut_h1 (
        .clk(clk), .rst_n(rst_b_n), .req(req_b), .a(a_b),
        .gnt(gnt_b), .sel(sel_b), .y(y_b), .y_valid(y_valid_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r, input logic [3:0] d);
        rst_n = 1'b0;
        req   = r;
        a     = d;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rst_b_n = 1'b0;
        req = 4'b0000; a = 4'b0000;
        req_b = 4'b0101; a_b = 4'b0001;
        #2;
        check("rst_gnt", 8'(gnt), 8'h0);
        check("rst_sel", 8'(sel), 8'h0);
        check("rst_y", 8'(y), 8'h0);
        check("rst_y_valid", 8'(y_valid), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);

        // Reset mid-grant
        do_reset(4'b0010, 4'b0010);
        tick();
        check("mid_gnt_e1", 8'(gnt), 8'h2);
        check("mid_busy_e1", 8'(busy), 8'h1);
        check("mid_yv_e1", 8'(y_valid), 8'h0);
        tick();
        check("mid_beat1", 8'({y_valid, y}), 8'h3);
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("mid_async_gnt", 8'(gnt), 8'h0);
        check("mid_async_yv", 8'(y_valid), 8'h0);
        check("mid_async_busy", 8'(busy), 8'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_regrant", 8'(gnt), 8'h2);

        // Single requester, back-to-back regrant
        do_reset(4'b0100, 4'b0100);
        tick();
        check("single_gnt", 8'(gnt), 8'h4);
        check("single_sel", 8'(sel), 8'h2);
        check("single_yv0", 8'(y_valid), 8'h0);
        for (int k = 2; k <= 7; k++) begin
            tick();
            check($sformatf("single_beat%0d", k), 8'({gnt, y_valid, y}), 8'h13);
        end

        // Full rotation with all four requesting
        do_reset(4'b1111, 4'b1010);
        for (int k = 1; k <= 17; k++) begin
            tick();
            check($sformatf("rot_sel_e%0d", k), 8'(sel), 8'(((k - 1) / 4) % 4));
            if (k >= 2) begin
                check($sformatf("rot_y_e%0d", k), 8'({y_valid, y}),
                      8'({1'b1, ((((k - 2) / 4) % 4) % 2) == 1}));
            end
        end

        // Early drop of requester 3 with requester 1 waiting
        do_reset(4'b1000, 4'b1000);
        tick();
        check("drop_gnt3", 8'(gnt), 8'h8);
        req = 4'b1010;
        tick();
        check("drop_beat1", 8'({gnt, y_valid, y}), 8'h23);
        tick();
        check("drop_beat2", 8'({gnt, y_valid, y}), 8'h23);
        req = 4'b0010;
        tick();
        check("drop_edge", 8'({gnt, y_valid, y}), 8'h09);
        tick();
        check("drop_next", 8'({gnt, y_valid, y}), 8'h0a);

        // Fairness: after requester 1 releases, 0 beats 1
        do_reset(4'b0010, 4'b0000);
        tick();
        check("fair_g1", 8'(gnt), 8'h2);
        req = 4'b0000;
        tick();
        check("fair_idle", 8'({gnt, busy}), 8'h0);
        check("fair_sel_hold", 8'(sel), 8'h1);
        req = 4'b0011;
        tick();
        check("fair_win0", 8'(gnt), 8'h1);
        req = 4'b0000;
        tick();

        // HOLD=1: alternate 0,2 every cycle
        rst_b_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("h1_sel_e%0d", k), 8'(sel_b), (k % 2 == 1) ? 8'h0 : 8'h2);
            if (k >= 2) begin
                check($sformatf("h1_y_e%0d", k), 8'({y_valid_b, y_b}),
                      (k % 2 == 0) ? 8'h3 : 8'h2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
